// File: rtl/arm_mem_pkg.sv
// Shared types and helpers for the ArmCpu memory-side responder.
package arm_mem_pkg;

  // Boot-loader / responder operating phase
  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } mem_sys_state_t;

  // Byte address of the memory-mapped output register
  localparam logic [31:0] MMIO_ADDR_DEFAULT = 32'hFFFF_FFFC;

  // Width of a word index into a memory of the given depth (never below 1)
  function automatic int word_idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/arm_mem_system_boot_loader.sv
// Byte-serial boot loader: accepts little-endian image bytes, packs them into
// 32-bit instruction words and holds the CPU in reset until the image is done.
module boot_loader
  import arm_mem_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  localparam int AW = word_idx_w(IMEM_WORDS),
  localparam int CW = AW + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic          load_error,
  output logic          cpu_reset,
  output logic          run_mode,
  output logic          imem_we,
  output logic [AW-1:0] imem_waddr,
  output logic [31:0]   imem_wdata
);

  mem_sys_state_t state, state_nx;

  // Counter reaches IMEM_WORDS*4 exactly when one byte past capacity arrives.
  logic [CW-1:0] byte_cnt;
  logic [23:0]   asm_q;
  logic [1:0]    lane;
  logic          accept;
  logic          overflow;

  // Next-state, handshake and word-assembly decode
  always_comb begin
    state_nx   = state;
    load_ready = 1'b0;
    load_error = 1'b0;
    cpu_reset  = 1'b1;
    run_mode   = 1'b0;
    imem_we    = 1'b0;
    accept     = 1'b0;
    lane       = byte_cnt[1:0];
    imem_waddr = byte_cnt[AW+1:2];
    overflow   = (byte_cnt == CW'(IMEM_WORDS * 4));
    imem_wdata = 32'h0;

    // Lanes above the incoming byte are zero, which gives a padded partial word.
    case (lane)
      2'd0:    imem_wdata = {24'h0, load_data};
      2'd1:    imem_wdata = {16'h0, load_data, asm_q[7:0]};
      2'd2:    imem_wdata = {8'h0, load_data, asm_q[15:0]};
      default: imem_wdata = {load_data, asm_q};
    endcase

    case (state)
      LOAD: begin
        load_ready = reset;
        accept     = load_valid && reset;
        if (accept) begin
          if (overflow) begin
            state_nx = ERROR;
          end else begin
            imem_we = (lane == 2'd3) || load_last;
            if (load_last) state_nx = RUN;
          end
        end
      end
      RUN: begin
        cpu_reset = 1'b0;
        run_mode  = 1'b1;
      end
      ERROR: begin
        load_error = 1'b1;
      end
      default: state_nx = LOAD;
    endcase
  end

  // State register plus byte counter and partial-word assembly
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= LOAD;
      byte_cnt <= '0;
      asm_q    <= '0;
    end else begin
      state <= state_nx;
      if (accept && !overflow) begin
        byte_cnt <= byte_cnt + CW'(1);
        if (imem_we) asm_q <= '0;
        else         asm_q <= imem_wdata[23:0];
      end
    end
  end

endmodule

// File: rtl/arm_mem_system.sv
// Memory-side responder for the ArmCpu core: instruction RAM filled by the
// boot loader, data RAM and one memory-mapped output register.
module arm_mem_system
  import arm_mem_pkg::*;
#(
  parameter int          IMEM_WORDS = 64,
  parameter int          DMEM_WORDS = 64,
  parameter logic [31:0] MMIO_ADDR  = MMIO_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  input  logic [7:0]  load_data,
  input  logic        load_last,
  output logic        load_ready,
  output logic        load_error,
  output logic        cpu_reset,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic [31:0] alu_result,
  input  logic [31:0] write_data,
  input  logic        mem_write,
  output logic [31:0] read_data,
  output logic        mmio_valid,
  output logic [31:0] mmio_data
);

  localparam int          IAW        = word_idx_w(IMEM_WORDS);
  localparam int          DAW        = word_idx_w(DMEM_WORDS);
  localparam logic [31:0] IMEM_BYTES = 32'(IMEM_WORDS * 4);
  localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

  logic [31:0] imem [IMEM_WORDS];
  logic [31:0] dmem [DMEM_WORDS];

  logic           run_mode;
  logic           imem_we;
  logic [IAW-1:0] imem_waddr;
  logic [31:0]    imem_wdata;
  logic           is_mmio;
  logic           dmem_hit;
  logic           dmem_we;
  logic           mmio_we;

  boot_loader #(
    .IMEM_WORDS(IMEM_WORDS)
  ) u_boot_loader (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_error(load_error),
    .cpu_reset (cpu_reset),
    .run_mode  (run_mode),
    .imem_we   (imem_we),
    .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata)
  );

  // Address decode and combinational fetch / load muxing
  always_comb begin
    is_mmio  = (alu_result == MMIO_ADDR);
    dmem_hit = (alu_result < DMEM_BYTES);
    dmem_we  = run_mode && mem_write && !is_mmio && dmem_hit;
    mmio_we  = run_mode && mem_write && is_mmio;
    instr    = (pc < IMEM_BYTES) ? imem[pc[IAW+1:2]] : 32'h0;
    if (is_mmio)       read_data = mmio_data;
    else if (dmem_hit) read_data = dmem[alu_result[DAW+1:2]];
    else               read_data = 32'h0;
  end

  // Instruction memory written only by the boot loader; contents survive reset
  always_ff @(posedge clk) begin
    if (imem_we) imem[imem_waddr] <= imem_wdata;
  end

  // Data memory written by CPU stores; contents survive reset
  always_ff @(posedge clk) begin
    if (dmem_we) dmem[alu_result[DAW+1:2]] <= write_data;
  end

  // Output register and its one-cycle write strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmio_data  <= 32'h0;
      mmio_valid <= 1'b0;
    end else begin
      mmio_valid <= mmio_we;
      if (mmio_we) mmio_data <= write_data;
    end
  end

endmodule

// File: tb/tb_arm_mem_system.sv
// Self-checking bench for arm_mem_system: a byte-level model of the boot image,
// data RAM and output register is compared on every falling edge, plus
// hand-computed literal expectations for the directed scenarios.
module tb_arm_mem_system;

  localparam int          IMEM_WORDS = 64;
  localparam int          DMEM_WORDS = 64;
  localparam logic [31:0] MMIO       = 32'hFFFF_FFFC;

  logic        clk;
  logic        reset;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_error;
  logic        cpu_reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic [31:0] alu_result;
  logic [31:0] write_data;
  logic        mem_write;
  logic [31:0] read_data;
  logic        mmio_valid;
  logic [31:0] mmio_data;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  arm_mem_system #(
    .IMEM_WORDS(IMEM_WORDS),
    .DMEM_WORDS(DMEM_WORDS),
    .MMIO_ADDR (MMIO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load_valid(load_valid),
    .load_data (load_data),
    .load_last (load_last),
    .load_ready(load_ready),
    .load_error(load_error),
    .cpu_reset (cpu_reset),
    .pc        (pc),
    .instr     (instr),
    .alu_result(alu_result),
    .write_data(write_data),
    .mem_write (mem_write),
    .read_data (read_data),
    .mmio_valid(mmio_valid),
    .mmio_data (mmio_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 = loading, 1 = running, 2 = overflowed
  int          m_phase = 0;
  int          m_count = 0;
  logic [7:0]  m_bytes [4];
  logic [31:0] m_imem [IMEM_WORDS];
  bit          m_ik [IMEM_WORDS];
  logic [31:0] m_dmem [DMEM_WORDS];
  bit          m_dk [DMEM_WORDS];
  logic [31:0] m_mmio = 32'h0;
  bit          m_mmio_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Advance the behavioural model on each clock edge and on reset assertion
  always @(posedge clk or negedge reset) begin
    int w, k;
    if (!reset) begin
      m_phase      = 0;
      m_count      = 0;
      m_mmio       = 32'h0;
      m_mmio_valid = 1'b0;
    end else begin
      m_mmio_valid = 1'b0;
      if (m_phase == 0 && load_valid) begin
        if (m_count == IMEM_WORDS * 4) begin
          m_phase = 2;
        end else begin
          w = m_count / 4;
          k = m_count % 4;
          m_bytes[k] = load_data;
          if (k == 3 || load_last) begin
            m_imem[w] = 32'h0;
            for (int j = 0; j <= k; j++)
              m_imem[w] = m_imem[w] | (32'(m_bytes[j]) << (8 * j));
            m_ik[w] = 1'b1;
          end
          if (load_last) m_phase = 1;
          m_count++;
        end
      end else if (m_phase == 1 && mem_write) begin
        if (alu_result == MMIO) begin
          m_mmio       = write_data;
          m_mmio_valid = 1'b1;
        end else if (alu_result < 32'(DMEM_WORDS * 4)) begin
          m_dmem[alu_result >> 2] = write_data;
          m_dk[alu_result >> 2]   = 1'b1;
        end
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (cmp_en) begin
      checkOutput("cpu_reset",  32'(cpu_reset),  32'(m_phase != 1));
      checkOutput("load_ready", 32'(load_ready), 32'(m_phase == 0 && reset == 1'b1));
      checkOutput("load_error", 32'(load_error), 32'(m_phase == 2));
      checkOutput("mmio_valid", 32'(mmio_valid), 32'(m_mmio_valid));
      checkOutput("mmio_data",  mmio_data,       m_mmio);
      if (pc >= 32'(IMEM_WORDS * 4))
        checkOutput("instr_oor", instr, 32'h0);
      else if (m_ik[pc >> 2])
        checkOutput("instr", instr, m_imem[pc >> 2]);
      if (alu_result == MMIO)
        checkOutput("read_mmio", read_data, m_mmio);
      else if (alu_result >= 32'(DMEM_WORDS * 4))
        checkOutput("read_oor", read_data, 32'h0);
      else if (m_dk[alu_result >> 2])
        checkOutput("read_data", read_data, m_dmem[alu_result >> 2]);
    end
  end

  // Drive one cycle of inputs and return 1 time unit after the consuming edge
  task automatic applyStimulus(input logic lv, input logic [7:0] ld, input logic ll,
                               input logic mw, input logic [31:0] addr,
                               input logic [31:0] wd);
    load_valid = lv;
    load_data  = ld;
    load_last  = ll;
    mem_write  = mw;
    alu_result = addr;
    write_data = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    load_valid = 1'b0;
    load_last  = 1'b0;
    mem_write  = 1'b0;
  endtask

  task automatic syncEdge();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] boot1 [12];

  initial begin
    boot1 = '{8'h00, 8'h00, 8'h1E, 8'hE4, 8'h00, 8'h10, 8'h1E, 8'hE4,
              8'h00, 8'h00, 8'h01, 8'hE4};
    reset = 1'b0; load_valid = 1'b0; load_data = 8'h0; load_last = 1'b0;
    pc = 32'h0; alu_result = 32'h0; write_data = 32'h0; mem_write = 1'b0;
    cmp_en = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_cpu_reset",  32'(cpu_reset),  32'd1);
    checkOutput("rst_load_ready", 32'(load_ready), 32'd0);
    checkOutput("rst_mmio_data",  mmio_data,       32'h0);
    reset = 1'b1;
    #1;
    checkOutput("load_ready_up", 32'(load_ready), 32'd1);
    syncEdge();

    // Boot image of three words, last flagged on byte 12
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, boot1[i], (i == 11), 1'b0, 32'h0, 32'h0);
    idleInputs();
    checkOutput("boot_cpu_release", 32'(cpu_reset), 32'd0);
    pc = 32'h4;   #1; checkOutput("instr_pc4",  instr, 32'hE41E1000);
    pc = 32'h0;   #1; checkOutput("instr_pc0",  instr, 32'hE41E0000);
    pc = 32'hA;   #1; checkOutput("instr_pc10", instr, 32'hE4010000);
    pc = 32'h100; #1; checkOutput("instr_oor",  instr, 32'h0);
    syncEdge();

    // Data store with read-during-write
    applyStimulus(1'b0, 8'h0, 1'b0, 1'b1, 32'h10, 32'h1111_1111);
    mem_write = 1'b1; write_data = 32'hFFFF_FFFF;
    #1; checkOutput("rdw_old", read_data, 32'h1111_1111);
    syncEdge();
    mem_write = 1'b0;
    #1; checkOutput("rdw_new", read_data, 32'hFFFF_FFFF);
    syncEdge();
    applyStimulus(1'b0, 8'h0, 1'b0, 1'b1, 32'h400, 32'hA5A5_A5A5);
    mem_write = 1'b0;
    #1; checkOutput("oor_store_read", read_data, 32'h0);
    alu_result = 32'h10;
    #1; checkOutput("oor_store_no_alias", read_data, 32'hFFFF_FFFF);
    syncEdge();

    // Output register: single write, then back-to-back writes
    applyStimulus(1'b0, 8'h0, 1'b0, 1'b1, MMIO, 32'hDEAD_BEEF);
    mem_write = 1'b0;
    #1;
    checkOutput("mmio_pulse",    32'(mmio_valid), 32'd1);
    checkOutput("mmio_value",    mmio_data,       32'hDEAD_BEEF);
    checkOutput("mmio_readback", read_data,       32'hDEAD_BEEF);
    syncEdge();
    checkOutput("mmio_pulse_end", 32'(mmio_valid), 32'd0);
    applyStimulus(1'b0, 8'h0, 1'b0, 1'b1, MMIO, 32'h1);
    checkOutput("b2b_valid1", 32'(mmio_valid), 32'd1);
    checkOutput("b2b_data1",  mmio_data,       32'h1);
    applyStimulus(1'b0, 8'h0, 1'b0, 1'b1, MMIO, 32'h2);
    checkOutput("b2b_valid2", 32'(mmio_valid), 32'd1);
    checkOutput("b2b_data2",  mmio_data,       32'h2);
    idleInputs();
    syncEdge();

    // Reset asserted mid-cycle while running
    #1 reset = 1'b0;
    #1;
    checkOutput("midrst_cpu_reset",  32'(cpu_reset),  32'd1);
    checkOutput("midrst_mmio_data",  mmio_data,       32'h0);
    checkOutput("midrst_load_ready", 32'(load_ready), 32'd0);
    syncEdge();
    reset = 1'b1;

    // Reload six bytes with stalls; stores during the load must be ignored
    for (int i = 0; i < 11; i++) begin
      if (i % 2 == 1)
        applyStimulus(1'b0, 8'hEE, 1'b1, 1'b1, 32'h10, 32'h1234_5678);
      else
        applyStimulus(1'b1, 8'(8'h11 + i / 2), (i == 10), 1'b1, 32'h10, 32'h1234_5678);
    end
    idleInputs();
    checkOutput("reload_release", 32'(cpu_reset), 32'd0);
    pc = 32'h0; #1; checkOutput("reload_w0",   instr, 32'h1413_1211);
    pc = 32'h4; #1; checkOutput("reload_w1",   instr, 32'h0000_1615);
    pc = 32'h8; #1; checkOutput("reload_keep", instr, 32'hE401_0000);
    alu_result = 32'h10;
    #1; checkOutput("dmem_retained", read_data, 32'hFFFF_FFFF);
    syncEdge();

    // Overflowing image: 257 bytes without a last flag
    reset = 1'b0;
    syncEdge();
    reset = 1'b1;
    for (int i = 0; i < 257; i++)
      applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 32'h10, 32'h0);
    idleInputs();
    checkOutput("ovf_error",     32'(load_error), 32'd1);
    checkOutput("ovf_ready",     32'(load_ready), 32'd0);
    checkOutput("ovf_cpu_reset", 32'(cpu_reset),  32'd1);
    pc = 32'd252; #1; checkOutput("ovf_w63", instr, 32'hFFFE_FDFC);
    pc = 32'd0;   #1; checkOutput("ovf_w0",  instr, 32'h0302_0100);
    syncEdge();
    applyStimulus(1'b1, 8'h55, 1'b1, 1'b0, 32'h10, 32'h0);
    idleInputs();
    repeat (2) syncEdge();
    checkOutput("ovf_sticky", 32'(load_error), 32'd1);

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arm_mem_system.md
Name: arm_mem_system

Overview:
Memory-side responder for the ArmCpu single-cycle core. Receives pc, alu_result, write_data and mem_write from the CPU, and returns instr and read_data. Holds the CPU in reset while a byte-serial boot loader fills instruction memory, then releases it. Provides data RAM plus one memory-mapped output register, so benches and the top level see program results without probing internal registers.

Parameters:
IMEM_WORDS, 64, instruction memory depth in 32-bit words
DMEM_WORDS, 64, data memory depth in 32-bit words
MMIO_ADDR, 32'hFFFF_FFFC, byte address of the output register

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low (0 = reset)
load_valid  in  1  boot byte valid
load_data  in  8  boot byte
load_last  in  1  qualifies final boot byte
load_ready  out  1  boot byte accepted when load_valid && load_ready
load_error  out  1  image overflow, sticky until reset
cpu_reset  out  1  active-high reset to ArmCpu
pc  in  32  CPU fetch address
instr  out  32  fetched instruction
alu_result  in  32  CPU data address
write_data  in  32  CPU store data
mem_write  in  1  CPU store enable
read_data  out  32  load data to CPU
mmio_valid  out  1  one-cycle pulse on output-register write
mmio_data  out  32  output register value

Behaviour:
- State machine states: LOAD, RUN, ERROR.
- Reset (reset=0, async):
  - State goes to LOAD; cpu_reset=1 immediately, without waiting for a clock edge.
  - load_ready=0 while reset is asserted; load_error=0, mmio_valid=0, mmio_data=0.
  - Byte counter and assembly register are cleared. IMEM/DMEM contents are retained, not cleared.
- LOAD:
  - load_ready=1 and cpu_reset=1.
  - A byte is accepted on a rising edge when load_valid && load_ready. Cycles without load_valid are stalls; no byte is consumed.
  - Byte index i is little-endian: word i>>2, lane i[1:0]. Lane 0 holds bits [7:0].
  - On acceptance of lane 3, imem[word] <= {b3,b2,b1,b0}, written on the same edge.
  - Accepted byte with load_last=1: write the (partial) word with unfilled upper lanes = 0, and go to RUN.
  - Accepting byte index IMEM_WORDS*4 (one past capacity) without load_last: go to ERROR. Nothing is written.
- RUN:
  - cpu_reset=0 from the first cycle in RUN, i.e. it falls on the edge that accepts the last byte.
  - load_ready=0; load_valid is ignored.
- ERROR:
  - load_error=1, load_ready=0, cpu_reset=1.
  - Left only by reset.
- Fetch (combinational, all states):
  - instr = imem[pc[log2(IMEM_WORDS)+1:2]]; pc[1:0] is ignored.
  - pc >= IMEM_WORDS*4 returns 32'h0000_0000.
- Data read (combinational):
  - alu_result == MMIO_ADDR returns mmio_data.
  - Otherwise, an in-range word address returns dmem[alu_result[..:2]]; out of range returns 0.
- Store (rising edge, RUN only):
  - mem_write with alu_result == MMIO_ADDR: mmio_data <= write_data, and mmio_valid=1 for exactly the following cycle.
  - Other in-range address: dmem write.
  - Out of range: write silently dropped.
  - mem_write in LOAD or ERROR is ignored.
- Same-address read during write: read_data shows the old value during the store cycle and the new value after the edge.
- Back-to-back MMIO stores keep mmio_valid high for consecutive cycles, each with new data.
- Reset mid-RUN: cpu_reset rises asynchronously. A subsequent load overwrites IMEM from word 0; unwritten words keep their old contents.

Decomposition:
- Package arm_mem_pkg:
  - mem_sys_state_t enum {LOAD, RUN, ERROR}
  - MMIO_ADDR_DEFAULT
  - word-index width function
- Sub-module boot_loader: handshake, byte counter, lane assembly, FSM. It outputs imem write enable/address/data, cpu_reset and load_error.
- Top level: IMEM/DMEM arrays, read muxing, MMIO register.

Test Plan:
1. Reset, then load 12 bytes 00 00 1E E4 | 00 10 1E E4 | 00 00 01 E4 with load_last on byte 12 -> imem[0..2] = E41E0000, E41E1000, E4010000; cpu_reset=0 the cycle after; pc=4 gives instr=E41E1000.
2. Load 6 bytes 11..16, last on byte 6, with load_valid dropped every other cycle -> exactly 6 bytes accepted; imem[0]=14131211, imem[1]=00001615.
3. RUN: mem_write=1, alu_result=0x10, write_data=FFFFFFFF -> read_data at 0x10 is old value that cycle and FFFFFFFF next cycle; store to 0x400 leaves read_data at 0x400 = 0.
4. RUN: store DEADBEEF to FFFFFFFC -> mmio_valid=1 for exactly one cycle, mmio_data=DEADBEEF; load from FFFFFFFC returns DEADBEEF.
5. Stream 257 bytes, no load_last -> load_error=1, load_ready=0, cpu_reset stays 1; imem[63] holds bytes 252..255.
6. In RUN, drive reset=0 mid-cycle -> cpu_reset=1 and mmio_data=0 before the next edge; dmem contents unchanged after reload.
